dbus_arb: RTL and testbench
===========================

# dbus_arb

Two-master arbiter that shares the single 16-bit data bus between the CPU core (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits directly in front of `dbus`: it drives `dbus` address, write-data and write-enable, and steers `dbus` read data back to the master that issued the read. Ownership is governed by a burst counter, which gives a bounded-unfairness round-robin scheme so that neither master can starve the other.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum consecutive grants to one master while the other is waiting. Legal range is 1..15; a value of 1 gives pure alternation.

Ports (`mX` = `m0`, `m1`):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mX_req`  in  1  transfer request; held with addr/we/din until granted
- `mX_we`  in  1  1 = write, 0 = read
- `mX_addr`  in  16  byte/word address as decoded by `dbus`
- `mX_din`  in  16  write data
- `mX_gnt`  out  1  combinational grant; transfer occurs in any cycle with `mX_req & mX_gnt`
- `mX_rvld`  out  1  read data valid, one cycle after a granted read
- `mX_rdata`  out  16  read data; equals `bus_dout` when `mX_rvld`, else 0
- `bus_addr`  out  16  to `dbus.addr`
- `bus_din`  out  16  to `dbus.din`
- `bus_we`  out  1  to `dbus.we`
- `bus_dout`  in  16  from `dbus.dout` (valid the cycle after address)

## Operation
- State registers:
  - `last`: 1 bit, the owner of the most recent grant.
  - `cnt`: 4 bits, consecutive grants to `last`, saturating at 15.
  - `rd_pend`: 1 bit, a read was granted last cycle.
  - `rd_own`: 1 bit, the master of that pending read.
- Logical states:
  - IDLE: `cnt`=0.
  - OWN0: `last`=0, `cnt`≥1.
  - OWN1: `last`=1, `cnt`≥1.
- Grant rule, evaluated each cycle, with `rst`=0:
  - No requests: no grant; `bus_we`=0, `bus_addr`=0, `bus_din`=0.
  - Only one master requesting: that master is granted.
  - Both requesting and `cnt` < `MAX_BURST`: `last` is granted.
  - Both requesting and `cnt` ≥ `MAX_BURST`: `~last` is granted.
  - At most one `gnt` is high per cycle.
- Bus mux: the granted master's addr/din/we drive `bus_*` unmodified.
- Counter update on a grant to master g:
  - If g == `last`: `cnt` <= min(`cnt`+1, 15).
  - Otherwise: `last` <= g, `cnt` <= 1.
- Cycles with no grant: `cnt` <= 0 (the ownership streak ends; the next contention favours `last`).
- Read tracking: a granted read (`we`=0) sets `rd_pend`=1 and `rd_own`=g for the next cycle; otherwise `rd_pend`=0.
- Read return: `mX_rvld` = `rd_pend & (rd_own==X)`.
- Writes produce no response; a write is complete in its grant cycle.

## Timing
- Grant latency: 0 cycles. `gnt` is combinational from `req` and registered state, so a lone requester is served in the cycle it asserts `req`.
- Read latency: data appears on `mX_rdata` with `mX_rvld` exactly 1 cycle after the grant cycle, matching the registered bank select and synchronous RAM in `dbus`.
- Back-to-back accesses:
  - A new grant in cycle t+1 is allowed while the read from cycle t returns.
  - Reads from alternating masters return in order, one per cycle.
- Reset:
  - While `rst`=1, all `gnt`, `rvld` and `bus_we` are 0, and `bus_addr`/`bus_din` are 0.
  - Registers clear to `last`=0, `cnt`=0, `rd_pend`=0.
  - A read granted in the cycle before reset asserts is dropped: no `rvld` is produced.
- First contention after reset, or after any idle cycle, grants m0 if `last`=0.
- Saturation: `cnt` never wraps. With only one requester, `cnt` saturates at 15 and the grant continues uninterrupted.
- `MAX_BURST`=1 with both masters requesting continuously: grants alternate every cycle.
- A master dropping `req` before `gnt` is legal. No transfer occurs, and no state changes on its behalf.

## Test plan
- Reset, then m0 reads address 0x0003 alone:
  - `m0_gnt`=1 in the same cycle, `bus_addr`=0x0003, `bus_we`=0.
  - Next cycle: `m0_rvld`=1 and `m0_rdata` = the RAM word.
  - `m1_rvld` stays 0.
- Both masters request continuously with `MAX_BURST`=4, starting with m0 owning the bus:
  - Grant sequence is m0×4, m1×4, m0×4 and so on.
  - Each read's `rvld` goes to the correct master one cycle later.
- m1 writes 0x1234 to 0x1000 (io) while m0 is idle:
  - `bus_we`=1, `bus_din`=0x1234 in the grant cycle.
  - A subsequent m0 read of 0x1000 returns the gpio register value.
- Alternating reads with `MAX_BURST`=1: m0 reads 0x0001 and m1 reads 0x0002 every cycle.
  - `m0_rvld`/`m1_rvld` alternate each cycle.
  - Each master receives data from its own address.
- `rst` asserted in the cycle after an m1 read grant:
  - `m1_rvld` stays 0.
  - After release, contention grants m0 first.
- m0 alone requests for 20 cycles with `MAX_BURST`=4:
  - Granted every cycle; internal `cnt` saturates at 15.
  - When m1 then requests, m1 is granted on the next contention cycle.

Source files
------------

// File: rtl/dbus_arb.sv
// Two-master arbiter in front of the shared 16-bit data bus. A burst counter
// bounds how long one master may hold the bus while the other is waiting.
module dbus_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_din,
    output logic        m0_gnt,
    output logic        m0_rvld,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_din,
    output logic        m1_gnt,
    output logic        m1_rvld,
    output logic [15:0] m1_rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_din,
    output logic        bus_we,
    input  logic [15:0] bus_dout
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_own_q, rd_own_d;
    logic       gnt_any_s;
    logic       gnt_sel_s;

    // Grant decision: sel=1 selects m1; the streak owner keeps the bus until the limit
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_sel_s = 1'b0;
        if (rst) begin
            gnt_any_s = 1'b0;
            gnt_sel_s = 1'b0;
        end else if (m0_req && m1_req) begin
            gnt_any_s = 1'b1;
            gnt_sel_s = (cnt_q < BURST_LIM) ? last_q : ~last_q;
        end else if (m0_req) begin
            gnt_any_s = 1'b1;
            gnt_sel_s = 1'b0;
        end else if (m1_req) begin
            gnt_any_s = 1'b1;
            gnt_sel_s = 1'b1;
        end else begin
            gnt_any_s = 1'b0;
            gnt_sel_s = 1'b0;
        end
    end

    assign m0_gnt = gnt_any_s & ~gnt_sel_s;
    assign m1_gnt = gnt_any_s & gnt_sel_s;

    // Bus mux: granted master drives the bus, otherwise everything is zero
    always_comb begin
        bus_addr = 16'h0000;
        bus_din  = 16'h0000;
        bus_we   = 1'b0;
        if (gnt_any_s && gnt_sel_s) begin
            bus_addr = m1_addr;
            bus_din  = m1_din;
            bus_we   = m1_we;
        end else if (gnt_any_s) begin
            bus_addr = m0_addr;
            bus_din  = m0_din;
            bus_we   = m0_we;
        end else begin
            bus_addr = 16'h0000;
            bus_din  = 16'h0000;
            bus_we   = 1'b0;
        end
    end

    // Next state: streak counter saturates at 15 and clears on any idle cycle
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_pend_d = 1'b0;
        rd_own_d  = rd_own_q;
        if (gnt_any_s) begin
            if (gnt_sel_s == last_q) begin
                cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
            end else begin
                last_d = gnt_sel_s;
                cnt_d  = 4'd1;
            end
            rd_pend_d = ~bus_we;
            rd_own_d  = gnt_sel_s;
        end else begin
            cnt_d = 4'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b0;
            cnt_q     <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    // A read pending across a reset assertion is suppressed here
    assign m0_rvld  = rd_pend_q & ~rd_own_q & ~rst;
    assign m1_rvld  = rd_pend_q & rd_own_q & ~rst;
    assign m0_rdata = m0_rvld ? bus_dout : 16'h0000;
    assign m1_rdata = m1_rvld ? bus_dout : 16'h0000;

endmodule

// File: tb/tb_dbus_arb.sv
// Scoreboard bench for dbus_arb: two instances (MAX_BURST=4 and MAX_BURST=1),
// each with a small synchronous RAM plus one io register at 0x1000 behind it.
module tb_dbus_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [2][2];
    logic        we    [2][2];
    logic [15:0] addr  [2][2];
    logic [15:0] din   [2][2];
    logic        gnt   [2][2];
    logic        rvld  [2][2];
    logic [15:0] rdata [2][2];
    logic [15:0] baddr [2];
    logic [15:0] bdin  [2];
    logic [15:0] bdout [2];
    logic        bwe   [2];
    logic [15:0] mem   [2][16];
    logic [15:0] gpio  [2];
    logic [15:0] gpio_exp;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t q[4][$];

    dbus_arb #(.MAX_BURST(4)) u_arb4 (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_din(din[0][0]),
        .m0_gnt(gnt[0][0]), .m0_rvld(rvld[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_din(din[0][1]),
        .m1_gnt(gnt[0][1]), .m1_rvld(rvld[0][1]), .m1_rdata(rdata[0][1]),
        .bus_addr(baddr[0]), .bus_din(bdin[0]), .bus_we(bwe[0]), .bus_dout(bdout[0])
    );

    dbus_arb #(.MAX_BURST(1)) u_arb1 (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_din(din[1][0]),
        .m0_gnt(gnt[1][0]), .m0_rvld(rvld[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_din(din[1][1]),
        .m1_gnt(gnt[1][1]), .m1_rvld(rvld[1][1]), .m1_rdata(rdata[1][1]),
        .bus_addr(baddr[1]), .bus_din(bdin[1]), .bus_we(bwe[1]), .bus_dout(bdout[1])
    );

    // Bus slaves: RAM word i holds 0xA000+i, io register at 0x1000; data returns one cycle later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) mem[d][i] <= 16'hA000 + 16'(i);
                gpio[d] <= 16'h5A5A;
            end else if (bwe[d]) begin
                if (baddr[d] == 16'h1000) gpio[d] <= bdin[d];
                else mem[d][baddr[d][3:0]] <= bdin[d];
            end
            bdout[d] <= (baddr[d] == 16'h1000) ? gpio[d] : mem[d][baddr[d][3:0]];
        end
    end

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        return (a == 16'h1000) ? gpio_exp : (16'hA000 + {12'h000, a[3:0]});
    endfunction

    // Drive one cycle on instance d, check grant and bus mux, queue expected read data
    task automatic apply(input int d,
                         input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                         input logic eg0, input logic eg1, input logic resp);
        logic        gw;
        logic [15:0] ga, gd;
        req[d][0] = r0; we[d][0] = w0; addr[d][0] = a0; din[d][0] = d0;
        req[d][1] = r1; we[d][1] = w1; addr[d][1] = a1; din[d][1] = d1;
        #1;
        checks++;
        if (gnt[d][0] !== eg0 || gnt[d][1] !== eg1) begin
            errors++;
            $display("FAIL gnt dut%0d cyc %0d: got m0=%b m1=%b want m0=%b m1=%b",
                     d, cyc, gnt[d][0], gnt[d][1], eg0, eg1);
        end
        if (eg0 || eg1) begin
            gw = eg1 ? w1 : w0;
            ga = eg1 ? a1 : a0;
            gd = eg1 ? d1 : d0;
            checks++;
            if (baddr[d] !== ga || bwe[d] !== gw || bdin[d] !== gd) begin
                errors++;
                $display("FAIL busmux dut%0d cyc %0d: got a=%h we=%b d=%h want a=%h we=%b d=%h",
                         d, cyc, baddr[d], bwe[d], bdin[d], ga, gw, gd);
            end
            if (!gw && resp) q[d*2 + (eg1 ? 1 : 0)].push_back(exp_t'{data: exp_rd(ga), due: cyc + 1});
            if (gw && ga == 16'h1000) gpio_exp = gd;
        end else begin
            checks++;
            if (baddr[d] !== 16'h0000 || bwe[d] !== 1'b0 || bdin[d] !== 16'h0000) begin
                errors++;
                $display("FAIL busidle dut%0d cyc %0d: got a=%h we=%b d=%h want zeros",
                         d, cyc, baddr[d], bwe[d], bdin[d]);
            end
        end
    endtask

    task automatic idle(input int d);
        apply(d, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: read data must arrive exactly on its due cycle, nothing unexpected, rdata 0 otherwise
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (q[d*2+m].size() > 0 && q[d*2+m][0].due == cyc) begin
                    checks++;
                    if (rvld[d][m] !== 1'b1 || rdata[d][m] !== q[d*2+m][0].data) begin
                        errors++;
                        $display("FAIL rdata dut%0d m%0d cyc %0d: got vld=%b data=%h want vld=1 data=%h",
                                 d, m, cyc, rvld[d][m], rdata[d][m], q[d*2+m][0].data);
                    end
                    void'(q[d*2+m].pop_front());
                end else begin
                    checks++;
                    if (rvld[d][m] !== 1'b0 || rdata[d][m] !== 16'h0000) begin
                        errors++;
                        $display("FAIL spurious_rvld dut%0d m%0d cyc %0d: got vld=%b data=%h want vld=0 data=0000",
                                 d, m, cyc, rvld[d][m], rdata[d][m]);
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        gpio_exp = 16'h5A5A;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = 16'h0000; din[d][m] = 16'h0000;
            end
        end
        repeat (2) @(negedge clk);
        // Requests held during reset must not be granted
        @(negedge clk);
        apply(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        apply(1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle(0);
        idle(1);

        // Lone m0 read of 0x0003: zero-latency grant, data next cycle
        @(negedge clk);
        apply(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); idle(0);

        // Continuous contention with MAX_BURST=4: m0 x4, m1 x4, m0 x4
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(0, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000,
                  ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, 1'b1);
        end
        @(negedge clk); idle(0);

        // m1 writes the io register, then m0 reads it back
        @(negedge clk);
        apply(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1000, 16'h1234, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        apply(0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); idle(0);

        // MAX_BURST=1: grants and read returns alternate every cycle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000,
                  (i % 2) == 0, (i % 2) == 1, 1'b1);
        end
        @(negedge clk); idle(1);

        // m1 read granted, reset next cycle: its data is dropped, then m0 wins contention
        @(negedge clk);
        apply(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        gpio_exp = 16'h5A5A;
        apply(0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); idle(0);

        // m0 alone long enough to saturate the counter, then m1 joins and wins at once
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            apply(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h0000,
                  i == 4, i < 4, 1'b1);
        end
        repeat (3) begin
            @(negedge clk); idle(0);
        end

        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (q[ch].size() != 0) begin
                errors++;
                $display("FAIL drain ch%0d: got %0d outstanding reads want 0", ch, q[ch].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
